// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Streams mnemonic-level commands into 32-bit MIPS32 machine words and writes
// them to instruction memory at an internally tracked PC. Branch and jump
// fields are derived from absolute byte targets. Commands that cannot be
// encoded are consumed without emitting anything and latched into a sticky,
// first-error-wins record.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          command handshake
//   in_kind, in_code           0 SPECIAL(funct) 1 OPC(opcode) 2 REGIMM 3 ORG
//   in_rs/rt/rd/shamt/imm      instruction fields
//   in_target                  absolute byte target (branch, j/jal, ORG)
//   out_valid/out_ready        IMEM write handshake
//   out_addr, out_word         IMEM write address / data
//   pc                         address of the next emitted word
//   err_valid/err_code/err_pc  sticky error record, err_clr clears it
module instr_encoder_loader #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [5:0]  in_code,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_word,
  output logic [31:0] pc,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [31:0] err_pc,
  input  logic        err_clr
);

  localparam logic [1:0] K_SPECIAL = 2'd0;
  localparam logic [1:0] K_OPC     = 2'd1;
  localparam logic [1:0] K_REGIMM  = 2'd2;
  localparam logic [1:0] K_ORG     = 2'd3;

  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [31:0] out_word_q, out_word_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [31:0] err_pc_q, err_pc_d;

  logic [31:0] pc_nxt, br_diff, word;
  logic [2:0]  br_err, cmd_err;
  logic [15:0] br_imm;
  logic [4:0]  f_rs, f_rt, f_rd, f_sh;
  logic        funct_ok, accept;

  // Encoder: produces the word and an error cause (0 = encodable).
  always_comb begin
    pc_nxt   = pc_q + 32'd4;
    br_diff  = in_target - pc_nxt;
    br_imm   = br_diff[17:2];
    // offset must fit 18 signed bits: bits 31..17 are pure sign extension
    if (br_diff[1:0] != 2'b00)
      br_err = 3'd2;
    else if ((br_diff[31:17] != '0) && (br_diff[31:17] != '1))
      br_err = 3'd3;
    else
      br_err = 3'd0;
    f_rs     = in_rs;
    f_rt     = in_rt;
    f_rd     = in_rd;
    f_sh     = in_shamt;
    funct_ok = 1'b0;
    word     = '0;
    cmd_err  = 3'd0;
    case (in_kind)
      K_SPECIAL: begin
        case (in_code)
          6'h00, 6'h02, 6'h03: f_rs = '0;
          default:             f_sh = '0;
        endcase
        case (in_code)
          6'h08:                      begin f_rt = '0; f_rd = '0; end
          6'h09:                      f_rt = '0;
          6'h18, 6'h19, 6'h1A, 6'h1B: f_rd = '0;
          6'h10, 6'h12:               begin f_rs = '0; f_rt = '0; end
          6'h11, 6'h13:               begin f_rt = '0; f_rd = '0; end
          default: ;
        endcase
        case (in_code)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C,
          6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: funct_ok = 1'b1;
          default:      funct_ok = 1'b0;
        endcase
        word = {6'h00, f_rs, f_rt, f_rd, f_sh, in_code};
        if (in_code == 6'h0C) word = 32'h0000_000C;
        if (!funct_ok) cmd_err = 3'd1;
      end
      K_OPC: begin
        case (in_code)
          6'h02, 6'h03: begin
            word = {in_code, in_target[27:2]};
            if (in_target[1:0] != 2'b00)
              cmd_err = 3'd2;
            else if (in_target[31:28] != pc_nxt[31:28])
              cmd_err = 3'd4;
          end
          6'h04, 6'h05, 6'h06, 6'h07: begin
            if (in_code[1]) f_rt = '0;
            word    = {in_code, f_rs, f_rt, br_imm};
            cmd_err = br_err;
          end
          6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
          6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
            if (in_code == 6'h0F) f_rs = '0;
            word = {in_code, f_rs, f_rt, in_imm};
          end
          default: cmd_err = 3'd1;
        endcase
      end
      K_REGIMM: begin
        word = {6'h01, in_rs, 4'b0000, in_code[0], br_imm};
        if (in_code > 6'd1)
          cmd_err = 3'd1;
        else
          cmd_err = br_err;
      end
      default: begin
        if (in_target[1:0] != 2'b00) cmd_err = 3'd2;
      end
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_word_d  = out_word_q;
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    err_pc_d    = err_pc_q;
    if (out_ready) out_valid_d = 1'b0;
    if (accept && (cmd_err == 3'd0)) begin
      if (in_kind == K_ORG) begin
        pc_d = in_target;
      end else begin
        out_valid_d = 1'b1;
        out_addr_d  = pc_q;
        out_word_d  = word;
        pc_d        = pc_nxt;
      end
    end
    if (err_clr) begin
      err_valid_d = 1'b0;
      err_code_d  = '0;
      err_pc_d    = '0;
    end
    // a clear in the same cycle frees the record for the new error
    if (accept && (cmd_err != 3'd0) && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_code_d  = cmd_err;
      err_pc_d    = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_word_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_word_q  <= out_word_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign pc        = pc_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_word  = out_word_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_pc    = err_pc_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: directed scenarios followed by random
// commands under random backpressure, checked against a field-level encoder
// model and an expected-write queue.
module tb_instr_encoder_loader;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [5:0]  in_code;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [31:0] in_target;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_word, pc;
  logic        err_valid, err_clr;
  logic [2:0]  err_code;
  logic [31:0] err_pc;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_code(in_code),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_word(out_word), .pc(pc),
    .err_valid(err_valid), .err_code(err_code), .err_pc(err_pc),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mpc;
  logic        mev;
  logic [2:0]  mec;
  logic [31:0] mep;
  logic [31:0] qa[$];
  logic [31:0] qw[$];
  logic [31:0] last_w;
  bit          rand_bp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from field rules with plain arithmetic.
  function automatic void ref_enc(
    input logic [1:0] k, input logic [5:0] c,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
    input logic [15:0] imm, input logic [31:0] tgt, input logic [31:0] pc0,
    output logic [31:0] w, output logic [2:0] e);
    logic [31:0] nxt;
    int          bdiff;
    logic [2:0]  be;
    logic [15:0] boff;
    logic [4:0]  s, t, d, a;
    logic [5:0]  op;
    nxt   = pc0 + 32'd4;
    bdiff = int'(tgt - nxt);
    if (bdiff % 4 != 0) be = 3'd2;
    else if (bdiff < -131072 || bdiff > 131071) be = 3'd3;
    else be = 3'd0;
    boff = 16'(bdiff / 4);
    s = rs; t = rt; d = rd; a = sh; op = c;
    w = 32'd0; e = 3'd0;
    case (k)
      2'd0: begin
        if (!(c inside {6'h00, [6'h02:6'h04], [6'h06:6'h09], 6'h0C, [6'h10:6'h13],
                        [6'h18:6'h1B], [6'h20:6'h27], 6'h2A, 6'h2B})) e = 3'd1;
        if (c == 6'h00 || c == 6'h02 || c == 6'h03) s = 5'd0; else a = 5'd0;
        if (c == 6'h08 || c == 6'h11 || c == 6'h13) begin t = 5'd0; d = 5'd0; end
        if (c == 6'h09) t = 5'd0;
        if (c >= 6'h18 && c <= 6'h1B) d = 5'd0;
        if (c == 6'h10 || c == 6'h12) begin s = 5'd0; t = 5'd0; end
        w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(a) << 6) | 32'(c);
        if (c == 6'h0C) w = 32'd12;
      end
      2'd1: begin
        if (c == 6'h02 || c == 6'h03) begin
          w = (32'(c) << 26) | ((tgt & 32'h0FFF_FFFF) >> 2);
          if (tgt % 4 != 0) e = 3'd2;
          else if ((tgt >> 28) != (nxt >> 28)) e = 3'd4;
        end else if (c >= 6'h04 && c <= 6'h07) begin
          if (c >= 6'h06) t = 5'd0;
          w = (32'(c) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(boff);
          e = be;
        end else if (c inside {[6'h08:6'h0F], 6'h20, 6'h21, [6'h23:6'h25], 6'h28, 6'h29, 6'h2B}) begin
          if (c == 6'h0F) s = 5'd0;
          w = (32'(c) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(imm);
        end else begin
          e = 3'd1;
        end
      end
      2'd2: begin
        op = 6'h01;
        if (c > 6'd1) e = 3'd1;
        else begin
          w = (32'(op) << 26) | (32'(s) << 21) | (32'(c) << 16) | 32'(boff);
          e = be;
        end
      end
      default: if (tgt % 4 != 0) e = 3'd2;
    endcase
  endfunction

  task automatic model_reset();
    mpc = 32'h0000_3000; mev = 1'b0; mec = 3'd0; mep = 32'd0;
    qa.delete(); qw.delete();
  endtask

  // Present a command, wait (bounded) for acceptance, then check pc and errors.
  task automatic send(input logic [1:0] k, input logic [5:0] c, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [31:0] tgt);
    logic [31:0] w;
    logic [2:0]  e;
    bit          done;
    in_kind = k; in_code = c; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt; in_valid = 1'b1;
    done = 0;
    w = 32'd0;
    for (int n = 0; n < 64 && !done; n++) begin
      #1;
      if (in_ready) begin
        ref_enc(k, c, rs, rt, rd, sh, imm, tgt, mpc, w, e);
        if (e != 3'd0) begin
          if (!mev) begin mev = 1'b1; mec = e; mep = mpc; end
        end else if (k == 2'd3) begin
          mpc = tgt;
        end else begin
          qa.push_back(mpc); qw.push_back(w);
          mpc = mpc + 32'd4;
        end
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    last_w = w;
    #1;
    chk("pc", pc, mpc);
    chk("err_valid", 32'(err_valid), 32'(mev));
    chk("err_code", 32'(err_code), 32'(mec));
    chk("err_pc", err_pc, mep);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mev = 1'b0; mec = 3'd0; mep = 32'd0;
    #1;
    chk("clr_valid", 32'(err_valid), 32'd0);
    chk("clr_code", 32'(err_code), 32'd0);
    chk("clr_pc", err_pc, 32'd0);
  endtask

  // Scoreboard: a write happens at the next rising edge when valid and ready.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk("spurious_word", out_addr, 32'hFFFF_FFFF);
        end else begin
          chk("wr_addr", out_addr, qa.pop_front());
          chk("wr_word", out_word, qw.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [31:0] aa, aw, tgt, nxt;
    logic [1:0]  k;
    logic [5:0]  c;
    int          r;
    logic [5:0]  fl[27] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C,
                           6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20,
                           6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0]  ol[22] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
                           6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
                           6'h25, 6'h28, 6'h29, 6'h2B};

    rst_n = 1'b0; in_valid = 1'b0; in_kind = 2'd0; in_code = 6'd0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 16'd0;
    in_target = 32'd0; out_ready = 1'b1; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_err_pc", err_pc, 32'd0);
    rst_n = 1'b1;

    // addu, beq backwards, jal, syscall
    send(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 32'd0);
    chk("addu_valid", 32'(out_valid), 32'd1);
    chk("addu_addr", out_addr, 32'h0000_3000);
    chk("addu_word", out_word, 32'h0022_1821);
    chk("addu_pc", pc, 32'h0000_3004);
    send(2'd1, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 32'h0000_3000);
    chk("beq_word", out_word, 32'h1022_FFFE);
    send(2'd1, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 32'h0040_0010);
    chk("jal_word", out_word, 32'h0C10_0004);
    send(2'd0, 6'h0C, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'd0, 32'd0);
    chk("syscall_word", out_word, 32'h0000_000C);

    // backpressure with a second command waiting
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    send(2'd0, 6'h21, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 32'd0);
    aw = last_w;
    aa = mpc - 32'd4;
    in_kind = 2'd0; in_code = 6'h25; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_word_stable", out_word, aw);
      chk("bp_addr_stable", out_addr, aa);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'd0, 6'h25, 5'd7, 5'd8, 5'd9, 5'd0, 16'd0, 32'd0);
    chk("bp_second_addr", out_addr, aa + 32'd4);
    chk("bp_second_valid", 32'(out_valid), 32'd1);

    // error record
    send(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 32'h0000_3000);
    send(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 32'h0000_3002);
    chk("org_err_code", 32'(err_code), 32'd2);
    chk("org_err_pc", err_pc, 32'h0000_3000);
    chk("org_pc_kept", pc, 32'h0000_3000);
    send(2'd0, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 32'd0);
    chk("first_err_wins", 32'(err_code), 32'd2);
    clr_err();

    // branch reach at the positive limit
    send(2'd1, 6'h05, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 32'h0002_3004);
    chk("bne_far_err", 32'(err_code), 32'd3);
    clr_err();
    send(2'd1, 6'h05, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 32'h0002_3000);
    chk("bne_max_word", out_word, 32'h1422_7FFF);

    // pc wrap, then reset while a word is held
    send(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 32'hFFFF_FFFC);
    send(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 32'd0);
    chk("wrap_addr", out_addr, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'd0);
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_pc", pc, 32'h0000_3000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;

    // random commands under random backpressure
    rand_bp = 1;
    for (int n = 0; n < 300; n++) begin
      nxt = mpc + 32'd4;
      r = int'($urandom_range(0, 9));
      k = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if (k == 2'd0)
        c = ($urandom_range(0, 9) < 8) ? fl[$urandom_range(0, 26)] : 6'($urandom);
      else if (k == 2'd1)
        c = ($urandom_range(0, 9) < 8) ? ol[$urandom_range(0, 21)] : 6'($urandom);
      else if (k == 2'd2)
        c = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 1)) : 6'($urandom);
      else
        c = 6'($urandom);
      r = int'($urandom_range(0, 9));
      if (k == 2'd3) begin
        tgt = 32'h0000_3000 + 32'($urandom_range(0, 255)) * 4;
        if (r == 0) tgt = 32'hFFFF_FFF0;
        if (r == 1) tgt = tgt + 32'd2;
      end else if (k == 2'd1 && (c == 6'h02 || c == 6'h03)) begin
        tgt = {nxt[31:28], 26'($urandom), 2'b00};
        if (r == 0) tgt = tgt | 32'd1;
        if (r == 1) tgt = tgt ^ 32'h1000_0000;
      end else begin
        tgt = nxt + 32'(int'($urandom_range(0, 80)) - 40) * 4;
        if (r == 0) tgt = tgt + 32'($urandom_range(1, 3));
        if (r == 1) tgt = nxt + 32'h0001_FFFC;
        if (r == 2) tgt = nxt - 32'h0002_0000;
        if (r == 3) tgt = nxt + (($urandom_range(0, 1) == 1) ? 32'h0002_0000 : 32'hFFFD_FFFC);
      end
      send(k, c, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), tgt);
      if ($urandom_range(0, 11) == 0) clr_err();
    end
    rand_bp = 0;
    @(negedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("drain_queue_empty", 32'(qa.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streaming MIPS32 instruction encoder and loader. It accepts one mnemonic-level command per handshake, packs it into a 32-bit machine word using the field placement the core's decoder expects, and writes the word to instruction memory at an internally tracked PC. Branch offsets and jump fields are computed from absolute byte targets. Illegal or unencodable commands are dropped and reported through a sticky error record. It sits between the test/boot command source and the IMEM write port.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid` / `in_ready`  in / out  1  command handshake.
- `in_kind`  in  2  0 = SPECIAL (code is funct), 1 = OPC (code is primary opcode), 2 = REGIMM (code 0 = bltz, 1 = bgez), 3 = ORG.
- `in_code`  in  6  funct, opcode, or REGIMM selector.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register and shift fields.
- `in_imm`  in  16  immediate for non-branch I-type.
- `in_target`  in  32  absolute byte target for branch, j/jal and ORG.
- `out_valid` / `out_ready`  out / in  1  IMEM write handshake.
- `out_addr`, `out_word`  out  32 each  write address and encoded word.
- `pc`  out  32  address of the next emitted word.
- `err_valid`  out  1  sticky error flag.
- `err_code`  out  3  cause of the error.
- `err_pc`  out  32  PC at which the error occurred.
- `err_clr`  in  1  clears the error record.

## Operation
- Accept: `in_ready = !out_valid || out_ready`. A command is accepted when `in_valid && in_ready`.
- SPECIAL: the word is {6'h00, rs, rt, rd, shamt, funct}. Field forcing by funct:
  - sll/srl/sra (00/02/03): rs = 0.
  - All other functs: shamt = 0.
  - jr: rt = rd = 0.
  - jalr: rt = 0.
  - mult/multu/div/divu: rd = 0.
  - mfhi/mflo: rs = rt = 0.
  - mthi/mtlo: rt = rd = 0.
  - syscall: the whole word is 32'h0000_000C.
  - Supported functs: 00, 02–04, 06–09, 0C, 10–13, 18–1B, 20–27, 2A, 2B. Any other funct → error 1.
- OPC: I-type words are {opcode, rs, rt, imm}.
  - lui: rs = 0.
  - blez/bgtz: rt = 0.
  - Supported opcodes: 02–0F, 20, 21, 23–25, 28, 29, 2B. Opcodes 00/01 or any other value → error 1.
- Branches (beq, bne, blez, bgtz, and REGIMM): `diff = in_target - (pc+4)`, computed mod 2^32.
  - `diff[1:0] != 0` → error 2.
  - `diff[31:17]` not all equal (offset does not fit in 18 signed bits) → error 3.
  - Otherwise imm = `diff[17:2]`.
  - REGIMM word is {6'h01, rs, {4'b0, code[0]}, imm}. REGIMM code > 1 → error 1.
- j/jal: word is {opcode, in_target[27:2]}.
  - `in_target[1:0] != 0` → error 2.
  - `in_target[31:28] != (pc+4)[31:28]` → error 4.
- ORG: loads `pc <= in_target` and emits no word. `in_target[1:0] != 0` → error 2 and pc is left unchanged.
- Good instruction:
  - `out_addr <= pc`, `out_word <= word`, `out_valid <= 1`.
  - `pc <= pc + 4`, wrapping from FFFF_FFFC to 0.
- Errored command:
  - The command is consumed; nothing is emitted and pc is not changed.
  - If `err_valid == 0`, capture `err_code` and `err_pc = pc`, and set `err_valid`.
  - Later errors do not overwrite a held record (first error wins).
- `err_clr`: clears `err_valid`; `err_code` and `err_pc` become 0. If a new error occurs in the same cycle as `err_clr`, the new error is captured.
- Output register: `out_valid` clears when `out_ready` is high and no new word is loaded. `out_addr` and `out_word` stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: `pc = RESET_PC`; `out_valid = 0`; `out_addr = out_word = 0`; `err_valid = 0`; `err_code = 0`; `err_pc = 0`.
- Reset mid-operation discards any held word immediately, whatever the state of `out_ready`.
- Latency: a word accepted at edge t is presented from t with `out_valid = 1`. Throughput is one word per cycle while `out_ready` is held high.
- ORG and errored commands occupy one accept slot. When they are accepted in the same cycle the output is drained, `out_valid` falls at that edge.
- `pc` and the error record update on the accepting edge. Commands are never duplicated and never lost under backpressure.

## Test plan
- Reset, then addu with rs=1, rt=2, rd=3 → `out_addr` = 0x3000, `out_word` = 0x00221821, `pc` = 0x3004.
- Emit one word, then beq with rs=1, rt=2, target 0x3000 at pc 0x3004 → `out_word` = 0x1022FFFE. Then jal with target 0x00400010 → 0x0C100004. Then syscall with random fields → 0x0000000C.
- Hold `out_ready` = 0 for 3 cycles with 2 commands pending → `in_ready` = 0 and the first word is stable. Release → both words emitted in consecutive cycles, addresses +4 apart, no repeats.
- ORG with target 0x3002 → `err_code` = 2, `err_pc` = 0x3000, pc unchanged. Then SPECIAL funct 0x3F → record unchanged. `err_clr` → all error outputs = 0.
- At pc 0x3000, bne with target 0x00023004 → error 3. bne with target 0x00023000 → imm 0x7FFF.
- ORG 0xFFFFFFFC, then addu → `out_addr` = 0xFFFFFFFC and `pc` wraps to 0. Assert `rst_n` low while `out_valid` = 1 → `out_valid` = 0 immediately and `pc` = 0x3000.
